if_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the IF/ID pipeline register. Holds the PC and issues
//  one read at a time to instruction memory over a read/resp handshake. Buffers the returned word with
//  its PC and presents it to IF/ID with a valid flag, honouring downstream stall and branch/jump redirect.

---
 rtl/if_fetch_unit.sv | 131 +++++++++++++
 tb/tb_if_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues one imem read at a time,
// buffers the returned word with its PC and presents it to IF/ID.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   stall              downstream cannot accept; hold presented instruction
//   redirect_valid/pc  one-cycle flush request and its target
//   imem_read/address  read request to instruction memory
//   imem_resp/rdata    one-cycle response with the fetched word
//   valid_out          ir_out/pc_out valid (IF/ID loads on valid_out & ~stall)
//   ir_out, pc_out     buffered instruction and its PC
//   fetch_count        instructions delivered downstream, wraps at 2^32
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    output logic [31:0] ir_out,
    output logic [31:0] pc_out,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        FETCH,
        VALID,
        FLUSH
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] pc;
    logic [31:0] pc_n;
    logic [31:0] req_addr;
    logic [31:0] req_addr_n;
    logic [31:0] buf_ir;
    logic [31:0] buf_ir_n;
    logic [31:0] buf_pc;
    logic [31:0] buf_pc_n;
    logic [31:0] count;
    logic        count_en;
    logic [31:0] target;

    assign target = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            buf_ir   <= '0;
            buf_pc   <= '0;
            count    <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= req_addr_n;
            buf_ir   <= buf_ir_n;
            buf_pc   <= buf_pc_n;
            if (count_en) begin
                count <= count + 32'd1;
            end
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_addr_n = req_addr;
        buf_ir_n   = buf_ir;
        buf_pc_n   = buf_pc;
        count_en   = 1'b0;
        unique case (state)
            FETCH: begin
                if (redirect_valid) begin
                    pc_n = target;
                    // A response arriving now closes the old request, so
                    // the new one can start at once; otherwise wait it out.
                    if (imem_resp) begin
                        req_addr_n = target;
                    end else begin
                        state_n = FLUSH;
                    end
                end else if (imem_resp) begin
                    buf_ir_n = imem_rdata;
                    buf_pc_n = req_addr;
                    pc_n     = req_addr + 32'd4;
                    state_n  = VALID;
                end
            end
            VALID: begin
                if (redirect_valid) begin
                    pc_n       = target;
                    req_addr_n = target;
                    state_n    = FETCH;
                end else if (!stall) begin
                    count_en   = 1'b1;
                    req_addr_n = pc;
                    state_n    = FETCH;
                end
            end
            FLUSH: begin
                if (redirect_valid) begin
                    pc_n = target;
                end
                if (imem_resp) begin
                    req_addr_n = redirect_valid ? target : pc;
                    state_n    = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    assign imem_read    = !rst && (state == FETCH || state == FLUSH);
    assign imem_address = req_addr;
    assign valid_out    = (state == VALID) && !redirect_valid;
    assign ir_out       = buf_ir;
    assign pc_out       = buf_pc;
    assign fetch_count  = count;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a scripted memory pushes the
// words it expects to see delivered; a monitor pops them on each load.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        valid_out;
    logic [31:0] ir_out;
    logic [31:0] pc_out;
    logic [31:0] fetch_count;

    int tests;
    int fails;
    int delivered;
    logic [63:0] sb[$];

    if_fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_read(imem_read),
        .imem_address(imem_address),
        .imem_resp(imem_resp),
        .imem_rdata(imem_rdata),
        .valid_out(valid_out),
        .ir_out(ir_out),
        .pc_out(pc_out),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h60) return 32'h0000_0013;
        return {a[23:0], 8'h13};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Delivery monitor: every IF/ID load must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && valid_out && !stall) begin
            tests++;
            delivered++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_delivery pc=%h ir=%h expected none",
                         pc_out, ir_out);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                if ({pc_out, ir_out} !== e) begin
                    fails++;
                    $display("FAIL delivery got pc=%h ir=%h expected pc=%h ir=%h",
                             pc_out, ir_out, e[63:32], e[31:0]);
                end
            end
        end
    end

    // Waits for a request, answers after lat cycles, returns at the
    // start of the cycle after the response pulse.
    task automatic serve(input int lat, input bit keep, output logic [31:0] a);
        int n;
        n = 0;
        #1;
        while (imem_read !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        if (imem_read !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL serve_timeout imem_read=%b expected 1", imem_read);
        end
        a = imem_address;
        repeat (lat) tick();
        imem_resp  = 1'b1;
        imem_rdata = mem_word(a);
        if (keep) sb.push_back({a, mem_word(a)});
        tick();
        imem_resp  = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        #1;
        tests++;
        if (imem_read !== 1'b0) begin
            fails++;
            $display("FAIL reset_read got=%b expected 0", imem_read);
        end
        tests++;
        if ({valid_out, pc_out, ir_out, fetch_count} !== 97'd0) begin
            fails++;
            $display("FAIL reset_outs got v=%b pc=%h ir=%h cnt=%0d expected zeros",
                     valid_out, pc_out, ir_out, fetch_count);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (imem_read !== 1'b1 || imem_address !== 32'h60) begin
            fails++;
            $display("FAIL reset_first_req got rd=%b a=%h expected 1 00000060",
                     imem_read, imem_address);
        end
    endtask

    task automatic test_first_fetch();
        logic [31:0] a;
        serve(2, 1'b1, a);
        #1;
        tests++;
        if (valid_out !== 1'b1 || pc_out !== 32'h60 || ir_out !== 32'h13) begin
            fails++;
            $display("FAIL first_valid got v=%b pc=%h ir=%h expected 1 60 13",
                     valid_out, pc_out, ir_out);
        end
        tick();
        #1;
        tests++;
        if (imem_address !== 32'h64 || fetch_count !== 32'd1) begin
            fails++;
            $display("FAIL first_next got a=%h cnt=%0d expected 64 1",
                     imem_address, fetch_count);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        serve(1, 1'b1, a);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            tests++;
            if (valid_out !== 1'b1 || pc_out !== 32'h64 ||
                ir_out !== mem_word(32'h64) || imem_read !== 1'b0 ||
                fetch_count !== 32'd1) begin
                fails++;
                $display("FAIL stall_hold got v=%b pc=%h ir=%h rd=%b cnt=%0d expected 1 64 %h 0 1",
                         valid_out, pc_out, ir_out, imem_read, fetch_count,
                         mem_word(32'h64));
            end
        end
        stall = 1'b0;
        tick();
        #1;
        tests++;
        if (fetch_count !== 32'd2 || imem_address !== 32'h68 || imem_read !== 1'b1) begin
            fails++;
            $display("FAIL stall_release got cnt=%0d a=%h rd=%b expected 2 68 1",
                     fetch_count, imem_address, imem_read);
        end
    endtask

    task automatic test_redirect_flush();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        tests++;
        if (imem_read !== 1'b1 || imem_address !== 32'h68) begin
            fails++;
            $display("FAIL flush_hold got rd=%b a=%h expected 1 68",
                     imem_read, imem_address);
        end
        imem_resp  = 1'b1;
        imem_rdata = mem_word(32'h68);
        tick();
        imem_resp  = 1'b0;
        #1;
        tests++;
        if (valid_out !== 1'b0 || imem_address !== 32'h200 || imem_read !== 1'b1) begin
            fails++;
            $display("FAIL flush_next got v=%b a=%h rd=%b expected 0 200 1",
                     valid_out, imem_address, imem_read);
        end
    endtask

    task automatic test_redirect_on_resp();
        tick();
        imem_resp      = 1'b1;
        imem_rdata     = mem_word(32'h200);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        imem_resp      = 1'b0;
        redirect_valid = 1'b0;
        #1;
        tests++;
        if (valid_out !== 1'b0 || imem_address !== 32'h300 || imem_read !== 1'b1) begin
            fails++;
            $display("FAIL resp_redirect got v=%b a=%h rd=%b expected 0 300 1",
                     valid_out, imem_address, imem_read);
        end
    endtask

    task automatic test_redirect_stalled();
        logic [31:0] a;
        serve(0, 1'b0, a);
        stall = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h403;
        #1;
        tests++;
        if (valid_out !== 1'b0) begin
            fails++;
            $display("FAIL stalled_redirect_valid got=%b expected 0", valid_out);
        end
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        #1;
        tests++;
        if (imem_address !== 32'h400 || fetch_count !== 32'd2) begin
            fails++;
            $display("FAIL stalled_redirect_next got a=%h cnt=%0d expected 400 2",
                     imem_address, fetch_count);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        serve(1, 1'b1, a);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        serve(1, 1'b0, a);
        #1;
        tests++;
        if (imem_address !== 32'hFFFF_FFFC) begin
            fails++;
            $display("FAIL wrap_target got a=%h expected fffffffc", imem_address);
        end
        serve(0, 1'b1, a);
        tick();
        #1;
        tests++;
        if (imem_address !== 32'h0 || fetch_count !== 32'd4) begin
            fails++;
            $display("FAIL wrap_next got a=%h cnt=%0d expected 0 4",
                     imem_address, fetch_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            serve(0, 1'b1, a);
            tick();
        end
        #1;
        tests++;
        if (imem_address !== 32'h10 || fetch_count !== 32'd8 ||
            fetch_count !== delivered) begin
            fails++;
            $display("FAIL b2b got a=%h cnt=%0d seen=%0d expected 10 8 8",
                     imem_address, fetch_count, delivered);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        rst = 1'b1;
        #1;
        tests++;
        if (imem_read !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_read got=%b expected 0", imem_read);
        end
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if (imem_read !== 1'b1 || imem_address !== 32'h60 ||
            valid_out !== 1'b0 || fetch_count !== 32'd0) begin
            fails++;
            $display("FAIL rst_mid_after got rd=%b a=%h v=%b cnt=%0d expected 1 60 0 0",
                     imem_read, imem_address, valid_out, fetch_count);
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_left got=%0d expected 0", sb.size());
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        delivered      = 0;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_resp      = 1'b0;
        imem_rdata     = '0;
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_flush();
        test_redirect_on_resp();
        test_redirect_stalled();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
